// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM request/enable arbiter.
// Holds the SDRAM command codes, the default bus widths and the arbiter state encoding.
package sdram_arbiter_pkg;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MREG = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    // Default widths
    localparam int SDRAM_ADDR_W = 13;
    localparam int SDRAM_BANK_W = 2;
    localparam int SDRAM_DATA_W = 16;

    // Arbiter states
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// SDRAM arbiter: grants one of auto-refresh / write / read at a time and muxes the
// granted requester's command, address and bank onto the SDRAM pins. Before init_end,
// the sdram_init signals drive the pins.
// Optional feature: define SDRAM_ARB_RR_EN for write/read round-robin on ties
// (refresh always wins). Without it, priority is fixed: aref > wr > rd.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int BANK_W = SDRAM_BANK_W,
    parameter int DATA_W = SDRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [BANK_W-1:0] init_bank_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic [BANK_W-1:0] aref_bank_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_sdram_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    arb_state_t r_state;
    logic       r_aref_en;
    logic       r_wr_en;
    logic       r_rd_en;
    logic       w_pick_wr;
    logic       w_pick_rd;

`ifdef SDRAM_ARB_RR_EN
    logic       r_last_wr;   // 1: write was granted last, 0: read was granted last

    // Write/read selection: on a tie, grant whichever was not granted last
    always_comb begin
        w_pick_wr = wr_req & (~rd_req | ~r_last_wr);
        w_pick_rd = rd_req & ~w_pick_wr;
    end

    // Remember which of write/read was granted most recently (starts as "read last")
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_wr <= 1'b0;
        end else if ((r_state == ST_IDLE) && !aref_req && w_pick_wr) begin
            r_last_wr <= 1'b1;
        end else if ((r_state == ST_IDLE) && !aref_req && w_pick_rd) begin
            r_last_wr <= 1'b0;
        end else begin
            r_last_wr <= r_last_wr;
        end
    end
`else
    // Write/read selection: fixed priority, write before read
    always_comb begin
        w_pick_wr = wr_req;
        w_pick_rd = rd_req & ~wr_req;
    end
`endif

    // Grant FSM: state and grant enables move together on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_aref_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (init_end) r_state <= ST_IDLE;
                    else          r_state <= ST_INIT;
                end
                ST_IDLE: begin
                    if (aref_req) begin
                        r_state   <= ST_AREF;
                        r_aref_en <= 1'b1;
                    end else if (w_pick_wr) begin
                        r_state   <= ST_WRITE;
                        r_wr_en   <= 1'b1;
                    end else if (w_pick_rd) begin
                        r_state   <= ST_READ;
                        r_rd_en   <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_AREF: begin
                    if (aref_end) begin
                        r_state   <= ST_IDLE;
                        r_aref_en <= 1'b0;
                    end else begin
                        r_state   <= ST_AREF;
                    end
                end
                ST_WRITE: begin
                    if (wr_end) begin
                        r_state <= ST_IDLE;
                        r_wr_en <= 1'b0;
                    end else begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (rd_end) begin
                        r_state <= ST_IDLE;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_aref_en <= 1'b0;
                    r_wr_en   <= 1'b0;
                    r_rd_en   <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux from the registered state; pins are forced to NOP while reset is held
    always_comb begin
        sdram_cmd       = CMD_NOP;
        sdram_addr      = {ADDR_W{1'b0}};
        sdram_bank_addr = {BANK_W{1'b0}};
        sdram_dq_oe     = 1'b0;
        if (!rst_n) begin
            sdram_cmd = CMD_NOP;
        end else begin
            case (r_state)
                ST_INIT: begin
                    sdram_cmd       = init_cmd;
                    sdram_addr      = init_addr;
                    sdram_bank_addr = init_bank_addr;
                end
                ST_AREF: begin
                    sdram_cmd       = aref_cmd;
                    sdram_addr      = aref_addr;
                    sdram_bank_addr = aref_bank_addr;
                end
                ST_WRITE: begin
                    sdram_cmd       = wr_cmd;
                    sdram_addr      = wr_addr;
                    sdram_bank_addr = wr_bank_addr;
                    sdram_dq_oe     = wr_sdram_en;
                end
                ST_READ: begin
                    sdram_cmd       = rd_cmd;
                    sdram_addr      = rd_addr;
                    sdram_bank_addr = rd_bank_addr;
                end
                default: begin
                    sdram_cmd       = CMD_NOP;
                end
            endcase
        end
    end

    assign aref_en      = r_aref_en;
    assign wr_en        = r_wr_en;
    assign rd_en        = r_rd_en;
    assign sdram_dq_out = wr_data;

endmodule
